// File: rtl/ahb_default_slave.sv
// AHB default slave: answers every real transfer with a two-cycle ERROR response
// and keeps a sticky log of the first offending transfer plus a saturating error count.
module ahb_default_slave #(
   parameter int AHB_ADDR_WIDTH = 32,
   parameter int AHB_DATA_WIDTH = 32,
   parameter int ERR_CNT_WIDTH  = 8
) (
   input  logic                      hclk,
   input  logic                      hreset_n,
   input  logic                      hsel,
   input  logic [AHB_ADDR_WIDTH-1:0] haddr,
   input  logic [1:0]                htrans,
   input  logic                      hwrite,
   input  logic [2:0]                hsize,
   input  logic                      hready,
   output logic                      hreadyout,
   output logic [1:0]                hresp,
   output logic [AHB_DATA_WIDTH-1:0] hrdata,
   input  logic                      err_clr,
   output logic                      err_valid,
   output logic [AHB_ADDR_WIDTH-1:0] err_addr,
   output logic                      err_write,
   output logic [2:0]                err_size,
   output logic [ERR_CNT_WIDTH-1:0]  err_count,
   output logic [1:0]                dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ERR1 = 2'd1,
      ST_ERR2 = 2'd2
   } state_t;

   localparam logic [1:0] RESP_OKAY  = 2'b00;
   localparam logic [1:0] RESP_ERROR = 2'b01;
   localparam logic [ERR_CNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [ERR_CNT_WIDTH-1:0] CNT_ONE = {{(ERR_CNT_WIDTH-1){1'b0}}, 1'b1};

   state_t state_q, state_d;
   logic   hreadyout_q, hreadyout_d;
   logic [1:0] hresp_q, hresp_d;

   logic                      err_valid_q, err_valid_d;
   logic [AHB_ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
   logic                      err_write_q, err_write_d;
   logic [2:0]                err_size_q, err_size_d;
   logic [ERR_CNT_WIDTH-1:0]  err_count_q, err_count_d;

   logic accept;

   // NONSEQ and SEQ both have htrans[1] set; IDLE and BUSY do not.
   assign accept = hsel & hready & htrans[1];

   // State register; response outputs are flopped alongside so they never
   // see a combinational path from the bus inputs.
   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) begin
         state_q     <= ST_IDLE;
         hreadyout_q <= 1'b1;
         hresp_q     <= RESP_OKAY;
      end else begin
         state_q     <= state_d;
         hreadyout_q <= hreadyout_d;
         hresp_q     <= hresp_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: state_d = accept ? ST_ERR1 : ST_IDLE;
         ST_ERR1: state_d = ST_ERR2;
         ST_ERR2: state_d = accept ? ST_ERR1 : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Output decode is taken from the next state so the flops hold the
   // response that belongs to the state being entered.
   always_comb begin
      hreadyout_d = 1'b1;
      hresp_d     = RESP_OKAY;
      case (state_d)
         ST_ERR1: begin
            hreadyout_d = 1'b0;
            hresp_d     = RESP_ERROR;
         end
         ST_ERR2: begin
            hreadyout_d = 1'b1;
            hresp_d     = RESP_ERROR;
         end
         default: begin
            hreadyout_d = 1'b1;
            hresp_d     = RESP_OKAY;
         end
      endcase
   end

   // Error log: a clear in the same cycle as an accept still records the new transfer.
   always_comb begin
      err_valid_d = err_valid_q;
      err_addr_d  = err_addr_q;
      err_write_d = err_write_q;
      err_size_d  = err_size_q;
      err_count_d = err_count_q;
      if (err_clr) begin
         err_valid_d = 1'b0;
         err_addr_d  = '0;
         err_write_d = 1'b0;
         err_size_d  = 3'd0;
         err_count_d = '0;
      end
      if (accept) begin
         if (err_clr || !err_valid_q) begin
            err_valid_d = 1'b1;
            err_addr_d  = haddr;
            err_write_d = hwrite;
            err_size_d  = hsize;
         end
         if (err_clr) begin
            err_count_d = CNT_ONE;
         end else if (err_count_q != CNT_MAX) begin
            err_count_d = err_count_q + CNT_ONE;
         end
      end
   end

   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) begin
         err_valid_q <= 1'b0;
         err_addr_q  <= '0;
         err_write_q <= 1'b0;
         err_size_q  <= 3'd0;
         err_count_q <= '0;
      end else begin
         err_valid_q <= err_valid_d;
         err_addr_q  <= err_addr_d;
         err_write_q <= err_write_d;
         err_size_q  <= err_size_d;
         err_count_q <= err_count_d;
      end
   end

   assign hreadyout = hreadyout_q;
   assign hresp     = hresp_q;
   assign hrdata    = '0;
   assign err_valid = err_valid_q;
   assign err_addr  = err_addr_q;
   assign err_write = err_write_q;
   assign err_size  = err_size_q;
   assign err_count = err_count_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_ahb_default_slave.sv
// Self-checking bench for ahb_default_slave: a response/log model checked every
// cycle, plus literal checkpoints for the named scenarios.
module tb_ahb_default_slave;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int CW = 8;
   localparam int CNT_MAX = 255;

   logic          hclk;
   logic          hreset_n;
   logic          hsel;
   logic [AW-1:0] haddr;
   logic [1:0]    htrans;
   logic          hwrite;
   logic [2:0]    hsize;
   logic          hready;
   logic          hreadyout;
   logic [1:0]    hresp;
   logic [DW-1:0] hrdata;
   logic          err_clr;
   logic          err_valid;
   logic [AW-1:0] err_addr;
   logic          err_write;
   logic [2:0]    err_size;
   logic [CW-1:0] err_count;
   logic [1:0]    dbg_state;

   int n_cmp = 0;
   int n_bad = 0;

   ahb_default_slave #(
      .AHB_ADDR_WIDTH(AW),
      .AHB_DATA_WIDTH(DW),
      .ERR_CNT_WIDTH (CW)
   ) dut (
      .hclk     (hclk),
      .hreset_n (hreset_n),
      .hsel     (hsel),
      .haddr    (haddr),
      .htrans   (htrans),
      .hwrite   (hwrite),
      .hsize    (hsize),
      .hready   (hready),
      .hreadyout(hreadyout),
      .hresp    (hresp),
      .hrdata   (hrdata),
      .err_clr  (err_clr),
      .err_valid(err_valid),
      .err_addr (err_addr),
      .err_write(err_write),
      .err_size (err_size),
      .err_count(err_count),
      .dbg_state(dbg_state)
   );

   // clock
   initial hclk = 1'b0;
   always #5 hclk = ~hclk;

   // Model: rem = number of ERROR data-phase cycles still to be shown (2 = wait cycle).
   int          m_rem;
   logic        m_valid;
   logic [31:0] m_addr;
   logic        m_write;
   logic [2:0]  m_size;
   int          m_cnt;
   logic        m_acc;

   assign m_acc = hsel && hready && (htrans == 2'd2 || htrans == 2'd3);

   always @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) begin
         m_rem   <= 0;
         m_valid <= 1'b0;
         m_addr  <= '0;
         m_write <= 1'b0;
         m_size  <= '0;
         m_cnt   <= 0;
      end else begin
         m_rem <= (m_rem == 2) ? 1 : (m_acc ? 2 : 0);
         if (m_acc && (err_clr || !m_valid)) begin
            m_valid <= 1'b1;
            m_addr  <= haddr;
            m_write <= hwrite;
            m_size  <= hsize;
         end else if (err_clr) begin
            m_valid <= 1'b0;
            m_addr  <= '0;
            m_write <= 1'b0;
            m_size  <= '0;
         end
         if (err_clr)
            m_cnt <= m_acc ? 1 : 0;
         else if (m_acc)
            m_cnt <= (m_cnt < CNT_MAX) ? m_cnt + 1 : m_cnt;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // compare process: every cycle, away from the active edge
   always @(negedge hclk) begin
      chk("hreadyout", {63'd0, hreadyout}, {63'd0, m_rem != 2});
      chk("hresp", {62'd0, hresp}, (m_rem > 0) ? 64'd1 : 64'd0);
      chk("hrdata", {32'd0, hrdata}, 64'd0);
      chk("err_valid", {63'd0, err_valid}, {63'd0, m_valid});
      chk("err_addr", {32'd0, err_addr}, {32'd0, m_addr});
      chk("err_write", {63'd0, err_write}, {63'd0, m_write});
      chk("err_size", {61'd0, err_size}, {61'd0, m_size});
      chk("err_count", {56'd0, err_count}, 64'(m_cnt));
   end

   // driver: apply one cycle of inputs, return 1 time unit after the edge
   task automatic cyc(input logic sel, input logic [1:0] tr, input logic [31:0] a,
                      input logic w, input logic [2:0] sz, input logic rdy, input logic clr);
      hsel = sel; htrans = tr; haddr = a; hwrite = w; hsize = sz; hready = rdy; err_clr = clr;
      @(posedge hclk);
      #1;
   endtask

   task automatic idle_cyc();
      cyc(1'b0, 2'd0, 32'h0, 1'b0, 3'd0, 1'b1, 1'b0);
   endtask

   task automatic chk_bus(input string name, input logic rdy, input logic [1:0] rsp);
      chk({name, ".hreadyout"}, {63'd0, hreadyout}, {63'd0, rdy});
      chk({name, ".hresp"}, {62'd0, hresp}, {62'd0, rsp});
   endtask

   initial begin
      hreset_n = 1'b0;
      hsel = 1'b0; haddr = '0; htrans = 2'd0; hwrite = 1'b0; hsize = 3'd0;
      hready = 1'b1; err_clr = 1'b0;
      repeat (3) @(posedge hclk);
      #1;
      chk_bus("reset", 1'b1, 2'b00);
      chk("reset.err_count", {56'd0, err_count}, 64'd0);
      chk("reset.err_valid", {63'd0, err_valid}, 64'd0);
      hreset_n = 1'b1;
      idle_cyc();

      // single error
      cyc(1'b1, 2'd2, 32'h0000_3000, 1'b1, 3'd2, 1'b1, 1'b0);
      chk_bus("single.c1", 1'b0, 2'b01);
      cyc(1'b0, 2'd0, 32'h0, 1'b0, 3'd0, 1'b0, 1'b0);
      chk_bus("single.c2", 1'b1, 2'b01);
      idle_cyc();
      chk_bus("single.c3", 1'b1, 2'b00);
      chk("single.err_valid", {63'd0, err_valid}, 64'd1);
      chk("single.err_addr", {32'd0, err_addr}, 64'h3000);
      chk("single.err_write", {63'd0, err_write}, 64'd1);
      chk("single.err_size", {61'd0, err_size}, 64'd2);
      chk("single.err_count", {56'd0, err_count}, 64'd1);

      // back-to-back, after clearing the log
      cyc(1'b0, 2'd0, 32'h0, 1'b0, 3'd0, 1'b1, 1'b1);
      cyc(1'b1, 2'd2, 32'h0000_3000, 1'b0, 3'd1, 1'b1, 1'b0);
      chk_bus("b2b.c1", 1'b0, 2'b01);
      cyc(1'b1, 2'd3, 32'h0000_3004, 1'b0, 3'd1, 1'b0, 1'b0);
      chk_bus("b2b.c2", 1'b1, 2'b01);
      cyc(1'b1, 2'd3, 32'h0000_3004, 1'b0, 3'd1, 1'b1, 1'b0);
      chk_bus("b2b.c3", 1'b0, 2'b01);
      cyc(1'b0, 2'd0, 32'h0, 1'b0, 3'd0, 1'b0, 1'b0);
      chk_bus("b2b.c4", 1'b1, 2'b01);
      idle_cyc();
      chk_bus("b2b.c5", 1'b1, 2'b00);
      chk("b2b.err_addr", {32'd0, err_addr}, 64'h3000);
      chk("b2b.err_count", {56'd0, err_count}, 64'd2);

      // IDLE / BUSY / stalled NONSEQ
      cyc(1'b0, 2'd0, 32'h0, 1'b0, 3'd0, 1'b1, 1'b1);
      cyc(1'b1, 2'd0, 32'h0000_5000, 1'b0, 3'd2, 1'b1, 1'b0);
      chk_bus("idle", 1'b1, 2'b00);
      cyc(1'b1, 2'd1, 32'h0000_5004, 1'b0, 3'd2, 1'b1, 1'b0);
      chk_bus("busy", 1'b1, 2'b00);
      cyc(1'b1, 2'd2, 32'h0000_5008, 1'b1, 3'd2, 1'b0, 1'b0);
      chk_bus("stall", 1'b1, 2'b00);
      chk("stall.err_count", {56'd0, err_count}, 64'd0);
      chk("stall.err_valid", {63'd0, err_valid}, 64'd0);

      // saturation: 257 accepts, each followed by a stalled wait cycle
      for (int i = 0; i < 257; i++) begin
         cyc(1'b1, 2'd2, 32'h0000_6000 + 32'(i * 4), 1'b0, 3'd0, 1'b1, 1'b0);
         cyc(1'b1, 2'd3, 32'h0, 1'b0, 3'd0, 1'b0, 1'b0);
      end
      idle_cyc();
      chk("sat.err_count", {56'd0, err_count}, 64'd255);
      chk("sat.err_addr", {32'd0, err_addr}, 64'h6000);

      // clear alone, then clear with accept
      cyc(1'b0, 2'd0, 32'h0, 1'b0, 3'd0, 1'b1, 1'b1);
      chk("clr.err_count", {56'd0, err_count}, 64'd0);
      chk("clr.err_valid", {63'd0, err_valid}, 64'd0);
      chk("clr.err_addr", {32'd0, err_addr}, 64'd0);
      cyc(1'b1, 2'd2, 32'h0000_4000, 1'b1, 3'd1, 1'b1, 1'b1);
      chk("clracc.err_valid", {63'd0, err_valid}, 64'd1);
      chk("clracc.err_addr", {32'd0, err_addr}, 64'h4000);
      chk("clracc.err_count", {56'd0, err_count}, 64'd1);
      chk_bus("clracc.bus", 1'b0, 2'b01);
      cyc(1'b0, 2'd0, 32'h0, 1'b0, 3'd0, 1'b0, 1'b0);
      idle_cyc();

      // reset in the middle of an error response
      cyc(1'b1, 2'd2, 32'h0000_7000, 1'b0, 3'd2, 1'b1, 1'b0);
      chk_bus("rst.pre", 1'b0, 2'b01);
      hsel = 1'b0; htrans = 2'd0; hready = 1'b0;
      hreset_n = 1'b0;
      #1;
      chk_bus("rst.async", 1'b1, 2'b00);
      chk("rst.err_count", {56'd0, err_count}, 64'd0);
      @(posedge hclk);
      #1;
      hreset_n = 1'b1;
      idle_cyc();
      cyc(1'b1, 2'd2, 32'h0000_8000, 1'b1, 3'd0, 1'b1, 1'b0);
      chk_bus("post.c1", 1'b0, 2'b01);
      cyc(1'b0, 2'd0, 32'h0, 1'b0, 3'd0, 1'b0, 1'b0);
      chk_bus("post.c2", 1'b1, 2'b01);
      idle_cyc();
      chk_bus("post.c3", 1'b1, 2'b00);
      chk("post.err_addr", {32'd0, err_addr}, 64'h8000);
      chk("post.err_count", {56'd0, err_count}, 64'd1);

      repeat (2) idle_cyc();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ahb_default_slave.md
AHB_DEFAULT_SLAVE -- requirements
Module: ahb_default_slave

Interface
REQ-001 SHALL have parameter AHB_ADDR_WIDTH, default 32, address bus width.
REQ-002 SHALL have parameter AHB_DATA_WIDTH, default 32, read data width.
REQ-003 SHALL have parameter ERR_CNT_WIDTH, default 8, error counter width.
REQ-004 SHALL have port hclk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port hreset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port hsel  input  1  default-slave select, driven by the master-side decoder default_slv_sel.
REQ-007 SHALL have port haddr  input  AHB_ADDR_WIDTH  transfer address.
REQ-008 SHALL have port htrans  input  2  transfer type: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
REQ-009 SHALL have port hwrite  input  1  1 = write, 0 = read.
REQ-010 SHALL have port hsize  input  3  transfer size.
REQ-011 SHALL have port hready  input  1  bus-level ready; address phase accepted when high.
REQ-012 SHALL have port hreadyout  output  1  this slave's ready.
REQ-013 SHALL have port hresp  output  2  response: OKAY=00, ERROR=01.
REQ-014 SHALL have port hrdata  output  AHB_DATA_WIDTH  read data, constant zero.
REQ-015 SHALL have port err_clr  input  1  synchronous clear of the error log.
REQ-016 SHALL have port err_valid  output  1  error log holds a captured transfer.
REQ-017 SHALL have port err_addr  output  AHB_ADDR_WIDTH  address of first logged error.
REQ-018 SHALL have port err_write  output  1  hwrite of first logged error.
REQ-019 SHALL have port err_size  output  3  hsize of first logged error.
REQ-020 SHALL have port err_count  output  ERR_CNT_WIDTH  number of ERROR responses issued, saturating.

Function
REQ-021 SHALL define "accept" as hsel & hready & (htrans == NONSEQ or SEQ) at a rising edge.
REQ-022 SHALL implement FSM states IDLE, ERR1, ERR2.
REQ-023 IDLE: hreadyout=1, hresp=OKAY; on accept -> ERR1, else stay.
REQ-024 ERR1: hreadyout=0, hresp=ERROR; unconditionally -> ERR2 next cycle.
REQ-025 ERR2: hreadyout=1, hresp=ERROR; on accept -> ERR1 (back-to-back error), else -> IDLE.
REQ-026 SHALL produce the two-cycle ERROR response starting the cycle after accept; total data-phase length is 2 cycles.
REQ-027 SHALL answer selected IDLE or BUSY transfers with zero-wait OKAY and no FSM change or log update.
REQ-028 SHALL ignore hsel, htrans and haddr when hready=0 (no accept, no state change except ERR1->ERR2).
REQ-029 SHALL drive hrdata to all zeros in every state.
REQ-030 SHALL register hreadyout and hresp directly from FSM state (glitch-free, no combinational path from inputs).
REQ-031 On accept with err_valid=0, SHALL capture haddr, hwrite, hsize into err_addr/err_write/err_size and set err_valid=1 at the same edge that enters ERR1.
REQ-032 On accept with err_valid=1, SHALL leave err_addr/err_write/err_size unchanged (first error sticky).
REQ-033 SHALL increment err_count by 1 on every accept; at all-ones it SHALL hold (saturate, no wrap).
REQ-034 err_clr without accept SHALL clear err_valid, err_addr, err_write, err_size, err_count to 0 at the next edge.
REQ-035 err_clr with accept in the same cycle SHALL capture the new transfer: err_valid=1, fields = new transfer, err_count=1.
REQ-036 err_clr SHALL NOT affect the FSM or the bus response.

Reset
REQ-037 While hreset_n=0, SHALL force FSM=IDLE, hreadyout=1, hresp=OKAY, hrdata=0, err_valid=0, err_addr=0, err_write=0, err_size=0, err_count=0, asynchronously.
REQ-038 Reset asserted in ERR1 or ERR2 SHALL abort the response immediately; first accept after release is handled as from IDLE.

Verification
REQ-039 Single error: hsel=1, htrans=NONSEQ, haddr=0x0000_3000, hwrite=1, hsize=2, hready=1 -> next cycle hreadyout=0/hresp=01, then hreadyout=1/hresp=01, then IDLE OKAY; err_valid=1, err_addr=0x0000_3000, err_write=1, err_size=2, err_count=1.
REQ-040 Back-to-back: NONSEQ 0x3000 then SEQ 0x3004 accepted in ERR2 -> two consecutive ERR1/ERR2 pairs, no OKAY between; err_addr stays 0x3000, err_count=2.
REQ-041 IDLE/BUSY and stall: hsel=1 with htrans=IDLE, then BUSY, then NONSEQ with hready=0 -> hreadyout=1, hresp=00 throughout, err_count=0.
REQ-042 Saturation and clear: 257 accepted errors with ERR_CNT_WIDTH=8 -> err_count=255; err_clr alone -> all log outputs 0; err_clr with accept of 0x4000 -> err_valid=1, err_addr=0x4000, err_count=1.
REQ-043 Reset mid-response: hreset_n low during ERR1 -> hreadyout=1, hresp=00, err_count=0 immediately; after release a NONSEQ accept yields a normal two-cycle ERROR.
